// File: rtl/sram_banked_arb.sv
// Address-interleaved banked RAM shared by several requestor ports, with a
// round-robin arbiter per bank and a fixed one- or two-cycle read latency.
module sram_banked_arb #(
    parameter int NUM_PORTS  = 2,
    parameter int NUM_BANKS  = 4,
    parameter int DEPTH      = 1024,
    parameter int DATA_WIDTH = 128,
    parameter int MASK_UNIT  = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int MASK_WIDTH = (DATA_WIDTH + MASK_UNIT - 1) / MASK_UNIT,
    parameter int OUT_REG    = 0
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             req_valid,
    output logic [NUM_PORTS-1:0]             req_ready,
    input  logic [NUM_PORTS-1:0]             req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS*MASK_WIDTH-1:0]  req_mask,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_data,
    output logic [NUM_PORTS-1:0]             resp_valid,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]  resp_data
);
    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int ROW_BITS  = ADDR_WIDTH - BANK_BITS;
    localparam int ROW_DEPTH = DEPTH / NUM_BANKS;
    localparam int PTR_BITS  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef logic [DATA_WIDTH-1:0] word_t;

    function automatic word_t expand_mask(input logic [MASK_WIDTH-1:0] mask);
        word_t bits;
        bits = {DATA_WIDTH{1'b0}};
        for (int j = 0; j < DATA_WIDTH; j++) begin
            bits[j] = mask[j / MASK_UNIT];
        end
        return bits;
    endfunction

    function automatic word_t merge_word(input word_t old_word, input word_t new_word,
                                         input logic [MASK_WIDTH-1:0] mask);
        word_t wm;
        wm = expand_mask(mask);
        return (old_word & ~wm) | (new_word & wm);
    endfunction

    logic [ADDR_WIDTH-1:0] addr_s [NUM_PORTS];
    logic [BANK_BITS-1:0]  bank_s [NUM_PORTS];
    logic [ROW_BITS-1:0]   row_s  [NUM_PORTS];
    logic [NUM_PORTS-1:0]  grant_s;
    logic [NUM_BANKS-1:0]  bank_busy_s;
    logic [PTR_BITS-1:0]   rr_ptr_r  [NUM_BANKS];
    logic [PTR_BITS-1:0]   nxt_ptr_s [NUM_BANKS];
    int                    idx_s;
    logic                  hit_s;
    word_t                 mem_r [NUM_BANKS][ROW_DEPTH];
    logic [NUM_PORTS-1:0]  s1_valid_r;
    word_t                 s1_data_r [NUM_PORTS];

    // Split each port address into bank (low bits) and row.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            addr_s[p] = req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            bank_s[p] = addr_s[p][BANK_BITS-1:0];
            row_s[p]  = addr_s[p][ADDR_WIDTH-1:BANK_BITS];
        end
    end

    // Per-bank round robin: first contender at or after rr_ptr wins.
    always_comb begin
        grant_s = {NUM_PORTS{1'b0}};
        idx_s   = 0;
        hit_s   = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_busy_s[b] = 1'b0;
            nxt_ptr_s[b]   = rr_ptr_r[b];
            for (int k = 0; k < NUM_PORTS; k++) begin
                idx_s = (int'(rr_ptr_r[b]) + k) % NUM_PORTS;
                hit_s = !bank_busy_s[b] && req_valid[idx_s] && (bank_s[idx_s] == BANK_BITS'(b));
                grant_s[idx_s] = grant_s[idx_s] | hit_s;
                nxt_ptr_s[b]   = hit_s ? PTR_BITS'((idx_s + 1) % NUM_PORTS) : nxt_ptr_s[b];
                bank_busy_s[b] = bank_busy_s[b] | hit_s;
            end
        end
    end

    assign req_ready = grant_s;

    // Arbiter pointers advance past the port granted this cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < NUM_BANKS; b++) rr_ptr_r[b] <= {PTR_BITS{1'b0}};
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) rr_ptr_r[b] <= nxt_ptr_s[b];
        end
    end

    // Storage is deliberately not reset; out-of-range writes are dropped.
    always_ff @(posedge clock) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant_s[p] && req_write[p] && (32'(row_s[p]) < 32'(ROW_DEPTH))) begin
                mem_r[bank_s[p]][row_s[p]] <= merge_word(mem_r[bank_s[p]][row_s[p]],
                                                         req_data[p*DATA_WIDTH +: DATA_WIDTH],
                                                         req_mask[p*MASK_WIDTH +: MASK_WIDTH]);
            end
        end
    end

    // First read stage; data holds between responses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_r <= {NUM_PORTS{1'b0}};
            for (int p = 0; p < NUM_PORTS; p++) s1_data_r[p] <= {DATA_WIDTH{1'b0}};
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                s1_valid_r[p] <= grant_s[p] & ~req_write[p];
                if (grant_s[p] && !req_write[p]) begin
                    s1_data_r[p] <= mem_r[bank_s[p]][row_s[p]];
                end
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [NUM_PORTS-1:0] s2_valid_r;
            word_t                s2_data_r [NUM_PORTS];

            // Optional output stage for timing closure.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    s2_valid_r <= {NUM_PORTS{1'b0}};
                    for (int p = 0; p < NUM_PORTS; p++) s2_data_r[p] <= {DATA_WIDTH{1'b0}};
                end else begin
                    s2_valid_r <= s1_valid_r;
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        if (s1_valid_r[p]) s2_data_r[p] <= s1_data_r[p];
                    end
                end
            end

            assign resp_valid = s2_valid_r;
            // Flatten per-port response words.
            always_comb begin
                resp_data = {(NUM_PORTS*DATA_WIDTH){1'b0}};
                for (int p = 0; p < NUM_PORTS; p++) resp_data[p*DATA_WIDTH +: DATA_WIDTH] = s2_data_r[p];
            end
        end else begin : g_no_out_reg
            assign resp_valid = s1_valid_r;
            // Flatten per-port response words.
            always_comb begin
                resp_data = {(NUM_PORTS*DATA_WIDTH){1'b0}};
                for (int p = 0; p < NUM_PORTS; p++) resp_data[p*DATA_WIDTH +: DATA_WIDTH] = s1_data_r[p];
            end
        end
    endgenerate

    sram_banked_arb_chk #(
        .NUM_PORTS  (NUM_PORTS),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_chk (
        .clock    (clock),
        .reset    (reset),
        .accept   (grant_s),
        .req_addr (req_addr)
    );
endmodule

// Flags any accepted request whose word address lies beyond the populated depth.
module sram_banked_arb_chk #(
    parameter int NUM_PORTS  = 2,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input logic                            clock,
    input logic                            reset,
    input logic [NUM_PORTS-1:0]            accept,
    input logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr
);
    // Address range check on every accepted request.
    always @(posedge clock) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (!reset && accept[p]) begin
                assert (32'(req_addr[p*ADDR_WIDTH +: ADDR_WIDTH]) < 32'(DEPTH))
                else $error("accepted address beyond DEPTH on port %0d", p);
            end
        end
    end
endmodule

// File: tb/tb_sram_banked_arb.sv
// Directed bench for sram_banked_arb: one instance without and one with the
// output register, driven by identical stimulus.
module tb_sram_banked_arb;
    localparam int NP = 2;
    localparam int AW = 10;
    localparam int DW = 128;
    localparam int MW = 16;

    localparam logic [DW-1:0] D_A5   = {16{8'hA5}};
    localparam logic [DW-1:0] D_ONES = {16{8'hFF}};
    localparam logic [DW-1:0] D_FF00 = {{15{8'hFF}}, 8'h00};
    localparam logic [DW-1:0] D_11   = {16{8'h11}};
    localparam logic [DW-1:0] D_22   = {16{8'h22}};
    localparam logic [DW-1:0] D_33   = {16{8'h33}};
    localparam logic [DW-1:0] D_44   = {16{8'h44}};

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [NP-1:0]    req_valid, req_write;
    logic [NP*AW-1:0] req_addr;
    logic [NP*MW-1:0] req_mask;
    logic [NP*DW-1:0] req_data;
    logic [NP-1:0]    ready0, ready1, rv0, rv1;
    logic [NP*DW-1:0] rd0, rd1;
    logic [1:0]       exp_g, prev_g;
    int n_checks = 0;
    int n_fail   = 0;

    sram_banked_arb #(.NUM_PORTS(NP), .NUM_BANKS(4), .DEPTH(1024), .DATA_WIDTH(DW),
                      .MASK_UNIT(8), .ADDR_WIDTH(AW), .MASK_WIDTH(MW), .OUT_REG(0)) dut0 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(ready0),
        .req_write(req_write), .req_addr(req_addr), .req_mask(req_mask), .req_data(req_data),
        .resp_valid(rv0), .resp_data(rd0));

    sram_banked_arb #(.NUM_PORTS(NP), .NUM_BANKS(4), .DEPTH(1024), .DATA_WIDTH(DW),
                      .MASK_UNIT(8), .ADDR_WIDTH(AW), .MASK_WIDTH(MW), .OUT_REG(1)) dut1 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(ready1),
        .req_write(req_write), .req_addr(req_addr), .req_mask(req_mask), .req_data(req_data),
        .resp_valid(rv1), .resp_data(rd1));

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int p, input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [MW-1:0] m, input logic [DW-1:0] d);
        req_valid[p] = v;
        req_write[p] = w;
        req_addr[p*AW +: AW] = a;
        req_mask[p*MW +: MW] = m;
        req_data[p*DW +: DW] = d;
    endtask

    task automatic idle();
        req_valid = 2'b00;
        req_write = 2'b00;
    endtask

    function automatic logic [DW-1:0] pd(input logic [NP*DW-1:0] v, input int p);
        return v[p*DW +: DW];
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        req_addr = '0;
        req_mask = '0;
        req_data = '0;
        #2 reset = 1'b1;
        tick();
        tick();
        chk("rst_valid0", DW'(rv0), 128'd0);
        chk("rst_valid1", DW'(rv1), 128'd0);
        chk("rst_data0", pd(rd0, 0), 128'd0);
        chk("rst_data1", pd(rd1, 1), 128'd0);
        reset = 1'b0;
        tick();

        // full write then read of addr 5
        drive(0, 1'b1, 1'b1, 10'd5, 16'hFFFF, D_A5);
        #1 chk("wr5_ready", DW'(ready0), DW'(2'b01));
        tick();
        idle();
        chk("wr_no_resp", DW'(rv0), 128'd0);
        drive(0, 1'b1, 1'b0, 10'd5, 16'h0000, 128'd0);
        tick();
        idle();
        chk("rd5_valid0", DW'(rv0), DW'(2'b01));
        chk("rd5_data0", pd(rd0, 0), D_A5);
        chk("rd5_early1", DW'(rv1), 128'd0);
        tick();
        chk("rd5_pulse0", DW'(rv0), 128'd0);
        chk("rd5_hold0", pd(rd0, 0), D_A5);
        chk("rd5_valid1", DW'(rv1), DW'(2'b01));
        chk("rd5_data1", pd(rd1, 0), D_A5);
        tick();
        chk("rd5_pulse1", DW'(rv1), 128'd0);

        // masked write clears lane 0 only
        drive(1, 1'b1, 1'b1, 10'd9, 16'hFFFF, D_ONES);
        tick();
        drive(1, 1'b1, 1'b1, 10'd9, 16'h0001, 128'd0);
        tick();
        drive(1, 1'b1, 1'b0, 10'd9, 16'h0000, 128'd0);
        tick();
        idle();
        chk("mask_valid", DW'(rv0), DW'(2'b10));
        chk("mask_data", pd(rd0, 1), D_FF00);

        // same-bank contention on bank 0
        drive(0, 1'b1, 1'b1, 10'd0, 16'hFFFF, D_11);
        tick();
        idle();
        drive(1, 1'b1, 1'b1, 10'd4, 16'hFFFF, D_22);
        tick();
        idle();
        drive(0, 1'b1, 1'b0, 10'd0, 16'h0000, 128'd0);
        drive(1, 1'b1, 1'b0, 10'd4, 16'h0000, 128'd0);
        prev_g = 2'b00;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            #1 chk("rr_ready", DW'(ready0), DW'(exp_g));
            tick();
            chk("rr_valid0", DW'(rv0), DW'(exp_g));
            chk("rr_data0", pd(rd0, i % 2), (i % 2 == 0) ? D_11 : D_22);
            if (i > 0) chk("rr_valid1", DW'(rv1), DW'(prev_g));
            prev_g = exp_g;
        end
        idle();
        tick();
        chk("rr_tail0", DW'(rv0), 128'd0);
        chk("rr_tail1", DW'(rv1), DW'(2'b10));

        // different banks proceed in parallel
        drive(0, 1'b1, 1'b1, 10'd1, 16'hFFFF, D_33);
        drive(1, 1'b1, 1'b1, 10'd2, 16'hFFFF, D_44);
        #1 chk("par_wr_ready", DW'(ready0), DW'(2'b11));
        tick();
        drive(0, 1'b1, 1'b0, 10'd1, 16'h0000, 128'd0);
        drive(1, 1'b1, 1'b0, 10'd2, 16'h0000, 128'd0);
        #1 chk("par_rd_ready", DW'(ready0), DW'(2'b11));
        tick();
        idle();
        chk("par_valid0", DW'(rv0), DW'(2'b11));
        chk("par_d0", pd(rd0, 0), D_33);
        chk("par_d1", pd(rd0, 1), D_44);
        tick();
        chk("par_valid1", DW'(rv1), DW'(2'b11));

        // three back-to-back reads on port 0
        drive(0, 1'b1, 1'b0, 10'd5, 16'h0000, 128'd0);
        tick();
        drive(0, 1'b1, 1'b0, 10'd9, 16'h0000, 128'd0);
        chk("b2b_v0_a", DW'(rv0), DW'(2'b01));
        chk("b2b_d0_a", pd(rd0, 0), D_A5);
        chk("b2b_v1_a", DW'(rv1), 128'd0);
        tick();
        drive(0, 1'b1, 1'b0, 10'd1, 16'h0000, 128'd0);
        chk("b2b_d0_b", pd(rd0, 0), D_FF00);
        chk("b2b_v1_b", DW'(rv1), DW'(2'b01));
        chk("b2b_d1_b", pd(rd1, 0), D_A5);
        tick();
        idle();
        chk("b2b_d0_c", pd(rd0, 0), D_33);
        chk("b2b_v1_c", DW'(rv1), DW'(2'b01));
        chk("b2b_d1_c", pd(rd1, 0), D_FF00);
        tick();
        chk("b2b_v0_d", DW'(rv0), 128'd0);
        chk("b2b_v1_d", DW'(rv1), DW'(2'b01));
        chk("b2b_d1_d", pd(rd1, 0), D_33);
        tick();
        chk("b2b_v1_e", DW'(rv1), 128'd0);

        // reset while a read is in flight; leaves bank 0 pointer at port 1
        drive(0, 1'b1, 1'b0, 10'd0, 16'h0000, 128'd0);
        tick();
        idle();
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_v0", DW'(rv0), 128'd0);
        chk("mid_rst_d0", pd(rd0, 0), 128'd0);
        chk("mid_rst_v1", DW'(rv1), 128'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_v1", DW'(rv1), 128'd0);
        chk("post_rst_v0", DW'(rv0), 128'd0);

        drive(0, 1'b1, 1'b0, 10'd0, 16'h0000, 128'd0);
        drive(1, 1'b1, 1'b0, 10'd4, 16'h0000, 128'd0);
        #1 chk("post_rst_ptr", DW'(ready0), DW'(2'b01));
        tick();
        chk("post_rst_d0", pd(rd0, 0), D_11);
        #1 chk("post_rst_next", DW'(ready0), DW'(2'b10));
        tick();
        idle();
        chk("post_rst_d1", pd(rd0, 1), D_22);

        // zero-mask write is granted, changes nothing, advances the pointer
        drive(0, 1'b1, 1'b1, 10'd0, 16'h0000, 128'd0);
        #1 chk("zm_ready", DW'(ready0), DW'(2'b01));
        tick();
        idle();
        chk("zm_no_resp", DW'(rv0), 128'd0);
        drive(0, 1'b1, 1'b0, 10'd0, 16'h0000, 128'd0);
        drive(1, 1'b1, 1'b0, 10'd4, 16'h0000, 128'd0);
        #1 chk("zm_ptr", DW'(ready0), DW'(2'b10));
        tick();
        chk("zm_d1", pd(rd0, 1), D_22);
        tick();
        idle();
        chk("zm_valid0", DW'(rv0), DW'(2'b01));
        chk("zm_d0", pd(rd0, 0), D_11);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
